// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the iterative divider
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_t;

  // Wide enough for any supported DW; the top slices off what it needs.
  localparam logic [63:0] DIV_ALL_ONES = '1;

endpackage

// File: rtl/mux_4.sv
// rtl/mux_4.sv - generic 4:1 word mux, sel=0..3 picks a1..a4
module mux_4 #(
  parameter int W = 32
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] a2,
  input  logic [W-1:0] a3,
  input  logic [W-1:0] a4,
  output logic [W-1:0] y
);

  always_comb begin
    y = a1;
    case (sel)
      2'd0:    y = a1;
      2'd1:    y = a2;
      2'd2:    y = a3;
      2'd3:    y = a4;
      default: y = a1;
    endcase
  end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - radix-2 restoring divider for DIV/DIVU/REM/REMU
// DIV_FAST_EN: finish special cases and |b|>|a| one cycle after acceptance
module div_unit
  import div_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] y
);

  localparam int CW = $clog2(DW) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);
  localparam logic [DW-1:0] QUO_ALL_ONES = DIV_ALL_ONES[DW-1:0];
  localparam logic [DW-1:0] SIGNED_MIN = {1'b1, {(DW-1){1'b0}}};

  div_state_t    state_q, state_d;
  div_op_t       op_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] quo_q, dvs_q, rem_q, y_q;
  logic [DW-1:0] spec_quo_q, spec_rem_q;
  logic          qneg_q, rneg_q, special_q;

  logic          accept;
  logic          in_signed, a_neg, b_neg;
  logic [DW-1:0] a_mag, b_mag;
  logic          in_div0, in_ovf, in_special;
  logic [DW-1:0] in_spec_quo, in_spec_rem;
  logic          fast_take;
  logic [DW-1:0] fast_y;

  logic [DW:0]   rem_shift;
  logic [DW+1:0] sub;
  logic          borrow;
  logic          unused_sub_msb;
  logic [DW-1:0] fix_quo, fix_rem, res_sel;
  logic          rem_op_q;

  assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
  assign in_signed = ~op[0];
  assign a_neg     = in_signed & a[DW-1];
  assign b_neg     = in_signed & b[DW-1];
  assign a_mag     = a_neg ? (~a + 1'b1) : a;
  assign b_mag     = b_neg ? (~b + 1'b1) : b;

  assign in_div0     = (b == '0);
  assign in_ovf      = in_signed && (a == SIGNED_MIN) && (b == QUO_ALL_ONES);
  assign in_special  = in_div0 || in_ovf;
  assign in_spec_quo = in_div0 ? QUO_ALL_ONES : a;
  assign in_spec_rem = in_div0 ? a : '0;

`ifdef DIV_FAST_EN
  // A divisor larger than the dividend gives q=0, r=a with no iteration needed.
  assign fast_take = in_special || (b_mag > a_mag);
  assign fast_y    = in_special ? (op[1] ? in_spec_rem : in_spec_quo)
                                : (op[1] ? a : '0);
`else
  assign fast_take = 1'b0;
  assign fast_y    = '0;
`endif

  // One shift-subtract-restore step on the DW+1 bit partial remainder.
  assign rem_shift      = {rem_q, quo_q[DW-1]};
  assign sub            = {1'b0, rem_shift} - {2'b00, dvs_q};
  assign borrow         = sub[DW+1];
  assign unused_sub_msb = sub[DW];

  assign fix_quo  = qneg_q ? (~quo_q + 1'b1) : quo_q;
  assign fix_rem  = rneg_q ? (~rem_q + 1'b1) : rem_q;
  assign rem_op_q = (op_q == REM) || (op_q == REMU);

  mux_4 #(.W(DW)) u_res_mux (
    .sel (({special_q, rem_op_q})),
    .a1  (fix_quo),
    .a2  (fix_rem),
    .a3  (spec_quo_q),
    .a4  (spec_rem_q),
    .y   (res_sel)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = fast_take ? DONE : CALC;
      CALC: if (cnt_q == LAST_ITER) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: begin
        if (accept) state_d = fast_take ? DONE : CALC;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= DIV;
      cnt_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      y_q        <= '0;
      spec_quo_q <= '0;
      spec_rem_q <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      special_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q       <= div_op_t'(op);
        cnt_q      <= '0;
        quo_q      <= a_mag;
        dvs_q      <= b_mag;
        rem_q      <= '0;
        spec_quo_q <= in_spec_quo;
        spec_rem_q <= in_spec_rem;
        qneg_q     <= a_neg ^ b_neg;
        rneg_q     <= a_neg;
        special_q  <= in_special;
        if (fast_take) y_q <= fast_y;
      end else if (state_q == CALC) begin
        quo_q <= {quo_q[DW-2:0], ~borrow};
        rem_q <= borrow ? rem_shift[DW-1:0] : sub[DW-1:0];
        cnt_q <= cnt_q + 1'b1;
      end else if (state_q == FIX) begin
        y_q <= res_sel;
      end
    end
  end

  assign busy = (state_q == CALC) || (state_q == FIX);
  assign done = (state_q == DONE);
  assign y    = y_q;

endmodule
